segasys1_collram_p: RTL and testbench
=====================================

SEGASYS1_COLLRAM_P -- requirements
Module: segasys1_collram_p

Interface
REQ-001 Parameter AW, default 6, SHALL set address width; depth is 2**AW one-bit entries (6 = mixer, 10 = sprite).
REQ-002 Parameter PAD, default 6'h3F, SHALL set the constant read bits [6:1].
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 cpu_ad  in  AW  CPU entry address.
REQ-006 cpu_wr_coll  in  1  CPU write strobe; clears entry cpu_ad.
REQ-007 cpu_wr_collclr  in  1  CPU write strobe; clears the summary flag.
REQ-008 clr_all  in  1  one-cycle pulse; starts a full-array clear sweep.
REQ-009 coll_ad  in  AW  video-side collision entry address.
REQ-010 coll  in  1  video-side collision event; sets entry coll_ad.
REQ-011 cpu_rd_coll  out  8  {summary, PAD, entry bit}.
REQ-012 busy  out  1  high while a clear sweep is in progress.

Function
REQ-013 coll=1 SHALL set core[coll_ad] and the summary flag on the same edge.
REQ-014 cpu_wr_coll=1 SHALL clear core[cpu_ad]; if coll targets the same address in the same cycle, the clear SHALL win.
REQ-015 CPU clear and coll at different addresses in one cycle SHALL both take effect.
REQ-016 cpu_wr_collclr SHALL clear the summary; a simultaneous coll SHALL leave it clear (CPU wins).
REQ-017 cpu_rd_coll[0] SHALL be registered: core[cpu_ad] sampled at edge N appears after edge N (1-cycle latency); bit 7 SHALL be the live summary register.
REQ-018 Sweep FSM: states IDLE, SWEEP; IDLE->SWEEP on clr_all, sweep counter loaded to 0.
REQ-019 In SWEEP each cycle SHALL clear core[counter] then increment; after clearing address 2**AW-1, the FSM SHALL return to IDLE (exactly 2**AW cycles).
REQ-020 busy SHALL equal (state==SWEEP), asserted the cycle after the clr_all edge.
REQ-021 coll to the address being swept in the same cycle SHALL win (entry ends set); coll to any other address SHALL behave per REQ-013.
REQ-022 clr_all during SWEEP SHALL restart the counter at 0.
REQ-023 The sweep SHALL NOT modify the summary flag.
REQ-024 CPU reads during SWEEP SHALL return current stored contents; no stall.

Reset
REQ-025 RESET SHALL force summary=0, read register=0, counter=0.
REQ-026 RESET SHALL place the FSM in SWEEP so the array self-clears after release; busy=1 during reset and for 2**AW cycles after release.
REQ-027 RESET asserted mid-sweep SHALL restart the sweep from 0 on release.

Configuration
REQ-028 Macro SEGASYS1_COLLRAM_SWEEP_EN defined: REQ-018..REQ-027 sweep behaviour SHALL be present.
REQ-029 Macro SEGASYS1_COLLRAM_SWEEP_EN undefined: no FSM or counter; clr_all SHALL be ignored, busy SHALL be tied 0, and core contents after reset SHALL be unspecified.

Structure
REQ-030 segasys1_video_pkg SHALL hold the sweep state enum (IDLE, SWEEP) and the default PAD constant.
REQ-031 The sweep FSM plus counter SHALL be a sub-module, segasys1_coll_sweep (params AW; outputs clr_en, clr_ad, busy).

Verification
REQ-032 After RESET release, AW=6: busy high exactly 64 cycles; every subsequent read gives bit0=0, cpu_rd_coll=8'h7E.
REQ-033 coll=1, coll_ad=5 -> read ad 5 one cycle later = 8'hFF; read ad 6 = 8'hFE.
REQ-034 Same cycle cpu_wr_coll ad 5 and coll ad 5 -> entry 5 = 0, summary = 1.
REQ-035 Same cycle cpu_wr_collclr and coll -> summary 0, coll entry set; read = 8'h7F at that address.
REQ-036 AW=10: set entries 0, 512, 1023; pulse clr_all; at sweep cycle 512 issue coll ad 512 -> after 1024 cycles only entry 512 set.
REQ-037 clr_all at sweep cycle 30 (AW=6) -> busy stays high 64 more cycles; build without SEGASYS1_COLLRAM_SWEEP_EN -> busy constantly 0, clr_all no effect.

Source files
------------

// File: rtl/segasys1_video_pkg.sv
// Shared types and constants for the Sega System 1 collision RAM.
package segasys1_video_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  localparam logic [5:0] PAD_DEFAULT = 6'h3F;

endpackage

// File: rtl/segasys1_coll_sweep.sv
// Clear-sweep sequencer: walks every collision entry once after reset or a clr_all pulse.
module segasys1_coll_sweep import segasys1_video_pkg::*; #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          clr_all,
  output logic          clr_en,
  output logic [AW-1:0] clr_ad,
  output logic          busy
);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_all) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == {AW{1'b1}}) begin
        state_d = IDLE;
      end
    end
  end

  // Reset lands in SWEEP so the array self-clears once reset is released.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == SWEEP);
  assign clr_en = busy;
  assign clr_ad = cnt_q;

endmodule

// File: rtl/segasys1_collram_p.sv
// One-bit-per-entry collision RAM with summary flag; the reset/clr_all clear sweep
// is built only when SEGASYS1_COLLRAM_SWEEP_EN is defined.
module segasys1_collram_p import segasys1_video_pkg::*; #(
  parameter int unsigned AW  = 6,
  parameter logic [5:0]  PAD = PAD_DEFAULT
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic [AW-1:0] cpu_ad,
  input  logic          cpu_wr_coll,
  input  logic          cpu_wr_collclr,
  input  logic          clr_all,
  input  logic [AW-1:0] coll_ad,
  input  logic          coll,
  output logic [7:0]    cpu_rd_coll,
  output logic          busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic             clr_en;
  logic [AW-1:0]    clr_ad;
  logic [Depth-1:0] core_q, core_d;
  logic             summary_q;
  logic             rd_q;

`ifdef SEGASYS1_COLLRAM_SWEEP_EN
  segasys1_coll_sweep #(
    .AW (AW)
  ) u_sweep (
    .clk     (clk),
    .RESET   (RESET),
    .clr_all (clr_all),
    .clr_en  (clr_en),
    .clr_ad  (clr_ad),
    .busy    (busy)
  );
`else
  logic unused_clr_all;
  assign unused_clr_all = clr_all;
  assign clr_en         = 1'b0;
  assign clr_ad         = '0;
  assign busy           = 1'b0;
`endif

  // Later assignments win: sweep clear < video set < CPU clear.
  always_comb begin
    core_d = core_q;
    if (clr_en) begin
      core_d[clr_ad] = 1'b0;
    end
    if (coll) begin
      core_d[coll_ad] = 1'b1;
    end
    if (cpu_wr_coll) begin
      core_d[cpu_ad] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    core_q <= core_d;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      summary_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      rd_q <= core_q[cpu_ad];
      if (cpu_wr_collclr) begin
        summary_q <= 1'b0;
      end else if (coll) begin
        summary_q <= 1'b1;
      end
    end
  end

  assign cpu_rd_coll = {summary_q, PAD, rd_q};

endmodule

// File: tb/tb_segasys1_collram_p.sv
// Scoreboard bench for segasys1_collram_p (AW=6 and AW=10 instances).
module tb_segasys1_collram_p;

`ifdef SEGASYS1_COLLRAM_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  localparam logic [7:0] SW_CLR = SW ? 8'hFE : 8'hFF;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [5:0] cpu_ad6 = '0, coll_ad6 = '0;
  logic       cpu_wr_coll6 = 0, cpu_wr_collclr6 = 0, clr_all6 = 0, coll6 = 0;
  logic [7:0] rd6;
  logic       busy6;
  logic [9:0] cpu_ad10 = '0, coll_ad10 = '0;
  logic       clr_all10 = 0, coll10 = 0;
  logic [7:0] rd10;
  logic       busy10;

  always #5 clk = ~clk;

  segasys1_collram_p #(.AW(6)) u_dut6 (
    .clk            (clk),
    .RESET          (RESET),
    .cpu_ad         (cpu_ad6),
    .cpu_wr_coll    (cpu_wr_coll6),
    .cpu_wr_collclr (cpu_wr_collclr6),
    .clr_all        (clr_all6),
    .coll_ad        (coll_ad6),
    .coll           (coll6),
    .cpu_rd_coll    (rd6),
    .busy           (busy6)
  );

  segasys1_collram_p #(.AW(10)) u_dut10 (
    .clk            (clk),
    .RESET          (RESET),
    .cpu_ad         (cpu_ad10),
    .cpu_wr_coll    (1'b0),
    .cpu_wr_collclr (1'b0),
    .clr_all        (clr_all10),
    .coll_ad        (coll_ad10),
    .coll           (coll10),
    .cpu_rd_coll    (rd10),
    .busy           (busy10)
  );

  typedef struct {
    int unsigned due;
    int          kind;  // 0 rd6, 1 busy6, 2 rd10, 3 busy10
    logic [7:0]  exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int unsigned due, int kind, logic [7:0] exp, string name);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire every expectation due at this cycle, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [7:0] act;
        case (sb[i].kind)
          0:       act = rd6;
          1:       act = {7'b0, busy6};
          2:       act = rd10;
          default: act = {7'b0, busy10};
        endcase
        checks++;
        if (sb[i].due < cyc) begin
          errors++;
          $display("FAIL %s: check missed at cycle %0d (due %0d)", sb[i].name, cyc, sb[i].due);
        end else if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: cycle %0d got %h want %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r, c, d;
    repeat (3) tick();
    push(cyc, 0, 8'h7E, "rst_rd6");
    push(cyc, 1, {7'b0, SW}, "rst_busy6");
    push(cyc, 2, 8'h7E, "rst_rd10");
    push(cyc, 3, {7'b0, SW}, "rst_busy10");
    tick();
    RESET = 1'b0;
    r = cyc;
    push(r, 1, {7'b0, SW}, "rel_busy6");
    push(r + 63, 1, {7'b0, SW}, "sweep_busy6_last");
    push(r + 64, 1, 8'h00, "sweep_busy6_done");
    push(r + 1023, 3, {7'b0, SW}, "sweep_busy10_last");
    push(r + 1024, 3, 8'h00, "sweep_busy10_done");

    // Explicit clear of every entry so the default build has defined contents too.
    for (int a = 0; a < 64; a++) begin
      cpu_ad6 = 6'(a);
      cpu_wr_coll6 = 1'b1;
      tick();
    end
    cpu_wr_coll6 = 1'b0;
    for (int a = 0; a < 64; a++) begin
      cpu_ad6 = 6'(a);
      push(cyc + 1, 0, 8'h7E, "init_rd");
      tick();
    end

    // Collision set, read latency, neighbour entry.
    c = cyc;
    cpu_ad6 = 6'd5; coll6 = 1'b1; coll_ad6 = 6'd5;
    push(c + 1, 0, 8'hFE, "coll5_summary");
    push(c + 2, 0, 8'hFF, "coll5_rd");
    tick();
    coll6 = 1'b0;
    tick();
    cpu_ad6 = 6'd6;
    push(cyc + 1, 0, 8'hFE, "ad6_rd");
    tick();

    // CPU clear beats collision at the same address.
    c = cyc;
    cpu_ad6 = 6'd5; cpu_wr_coll6 = 1'b1; coll6 = 1'b1; coll_ad6 = 6'd5;
    push(c + 1, 0, 8'hFF, "wr_vs_coll_old");
    push(c + 2, 0, 8'hFE, "wr_vs_coll_clr");
    tick();
    cpu_wr_coll6 = 1'b0; coll6 = 1'b0;
    tick();

    // CPU clear and collision at different addresses both land.
    c = cyc;
    coll6 = 1'b1; coll_ad6 = 6'd9; cpu_ad6 = 6'd9;
    push(c + 1, 0, 8'hFE, "pre9");
    tick();
    cpu_wr_coll6 = 1'b1; coll_ad6 = 6'd10;
    push(c + 2, 0, 8'hFF, "old9");
    tick();
    cpu_wr_coll6 = 1'b0; coll6 = 1'b0; cpu_ad6 = 6'd10;
    push(c + 3, 0, 8'hFF, "set10");
    tick();
    cpu_ad6 = 6'd9;
    push(c + 4, 0, 8'hFE, "clr9");
    tick();

    // Summary clear beats simultaneous collision; entry still set.
    c = cyc;
    cpu_ad6 = 6'd20; cpu_wr_collclr6 = 1'b1; coll6 = 1'b1; coll_ad6 = 6'd20;
    push(c + 1, 0, 8'h7E, "collclr_now");
    push(c + 2, 0, 8'h7F, "collclr_rd");
    tick();
    cpu_wr_collclr6 = 1'b0; coll6 = 1'b0;
    tick();

    // clr_all restart mid-sweep; summary untouched by the sweep.
    cpu_ad6 = 6'd40; coll6 = 1'b1; coll_ad6 = 6'd40;
    tick();
    coll6 = 1'b0;
    c = cyc;
    clr_all6 = 1'b1;
    push(c, 1, 8'h00, "pre_busy6");
    push(c + 1, 1, {7'b0, SW}, "clr_busy6_start");
    push(c + 45, 0, 8'hFF, "mid_sweep_rd");
    push(c + 94, 1, {7'b0, SW}, "restart_busy6_last");
    push(c + 95, 1, 8'h00, "restart_busy6_done");
    push(c + 97, 0, SW_CLR, "post_sweep_rd40");
    tick();
    clr_all6 = 1'b0;
    repeat (29) tick();
    clr_all6 = 1'b1;
    tick();
    clr_all6 = 1'b0;
    repeat (70) tick();

    // AW=10: collision to the address under sweep wins.
    while (cyc < r + 1030) tick();
    d = cyc;
    coll10 = 1'b1; coll_ad10 = 10'd0;
    tick();
    coll_ad10 = 10'd512;
    tick();
    coll_ad10 = 10'd1023;
    tick();
    coll10 = 1'b0; clr_all10 = 1'b1;
    push(d + 3, 3, 8'h00, "pre_busy10");
    tick();
    clr_all10 = 1'b0;
    push(d + 4, 3, {7'b0, SW}, "clr_busy10_start");
    push(d + 1027, 3, {7'b0, SW}, "clr_busy10_last");
    push(d + 1028, 3, 8'h00, "clr_busy10_done");
    while (cyc < d + 516) tick();
    coll10 = 1'b1; coll_ad10 = 10'd512;
    tick();
    coll10 = 1'b0;
    while (cyc < d + 1030) tick();
    cpu_ad10 = 10'd0;
    push(cyc + 1, 2, SW_CLR, "rd10_0");
    tick();
    cpu_ad10 = 10'd512;
    push(cyc + 1, 2, 8'hFF, "rd10_512");
    tick();
    cpu_ad10 = 10'd1023;
    push(cyc + 1, 2, SW_CLR, "rd10_1023");
    tick();
    repeat (3) tick();

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked (due %0d)", sb[i].name, sb[i].due);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
